// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
//   Shared encodings for the multi-cycle core controller: FSM state enum,
//   RV32 opcode constants, and the ALUControl / ResultSrc / ImmSrc codes.
//   The ALU and the datapath muxes decode the same codes.
package core_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_TRAP  = 3'd4
   } state_t;

   // Opcodes (Instr[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_CUST0  = 7'b0001011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ALUControl
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   // ResultSrc
   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   // ImmSrc
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/core_alu_decoder.sv
// core_alu_decoder
//   Combinational ALU operation decode.
//   Ports:
//     opcode    in  7  Instr[6:0]
//     funct3    in  3  Instr[14:12]
//     funct7_5  in  1  Instr[30]
//     alu_ctrl  out 4  ALUControl code (core_ctrl_pkg encodings)
module core_alu_decoder
   import core_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_ctrl
);

   logic w_is_arith;

   assign w_is_arith = (opcode == OP_R) || (opcode == OP_I_ALU) || (opcode == OP_CUST0);

   always_comb begin
      alu_ctrl = ALU_ADD;
      if (w_is_arith) begin
         case (funct3)
            // Instr[30] is immediate data for addi, so only R-type selects SUB
            3'b000:  alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLT;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
         endcase
      end else if (opcode == OP_BRANCH) begin
         alu_ctrl = ALU_SUB;
      end
   end

endmodule

// File: rtl/core_mc_controller.sv
// core_mc_controller
//   Multi-cycle control sequencer: fetches over a ready/valid imem handshake,
//   holds the instruction in Instr, and steps EXEC / MEM / WB driving all
//   datapath controls. Illegal opcodes park the FSM in TRAP until reset.
//   Ports:
//     clk, reset (sync, active-high)
//     imem_req/imem_ready/imem_rdata   instruction fetch handshake
//     Instr                            instruction register to datapath
//     Zero                             ALU zero flag (branch resolve)
//     dmem_req/dmem_ready, MemWrite    data access handshake
//     PCWrite, RegWrite, PCSrc, ALUSrc, SSSrc, ResultSrc, ImmSrc, ALUControl
//     trap                             sticky illegal-opcode flag
//     retired                          count of cycles with PCWrite = 1
module core_mc_controller
   import core_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   input  logic        Zero,
   output logic        dmem_req,
   input  logic        dmem_ready,
   output logic        MemWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        SSSrc,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [3:0]  ALUControl,
   output logic        trap,
   output logic [31:0] retired
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_instr;
   logic [31:0] r_retired;
   logic [6:0]  w_opcode;
   logic [3:0]  w_alu_ctrl;

   assign w_opcode   = r_instr[6:0];
   assign Instr      = r_instr;
   assign retired    = r_retired;
   assign ALUControl = w_alu_ctrl;

   core_alu_decoder u_alu_dec (
      .opcode   (w_opcode),
      .funct3   (r_instr[14:12]),
      .funct7_5 (r_instr[30]),
      .alu_ctrl (w_alu_ctrl)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_instr   <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && imem_ready)
            r_instr <= imem_rdata;
         if (PCWrite)
            r_retired <= r_retired + 32'd1;
      end
   end

   always_comb begin
      w_next    = r_state;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      MemWrite  = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      PCSrc     = 1'b0;
      ALUSrc    = 1'b0;
      SSSrc     = 1'b0;
      ResultSrc = RES_ALU;
      ImmSrc    = IMM_I;
      trap      = 1'b0;

      case (r_state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready)
               w_next = S_EXEC;
         end

         S_EXEC: begin
            case (w_opcode)
               OP_R, OP_I_ALU, OP_CUST0: begin
                  RegWrite = 1'b1;
                  PCWrite  = 1'b1;
                  ALUSrc   = (w_opcode == OP_I_ALU);
                  SSSrc    = (w_opcode == OP_CUST0);
                  w_next   = S_FETCH;
               end
               OP_LOAD: begin
                  ALUSrc = 1'b1;
                  ImmSrc = IMM_I;
                  w_next = S_MEM;
               end
               OP_STORE: begin
                  ALUSrc = 1'b1;
                  ImmSrc = IMM_S;
                  w_next = S_MEM;
               end
               OP_BRANCH: begin
                  ImmSrc  = IMM_B;
                  PCWrite = 1'b1;
                  PCSrc   = Zero;
                  w_next  = S_FETCH;
               end
               OP_JAL: begin
                  ImmSrc    = IMM_J;
                  PCSrc     = 1'b1;
                  PCWrite   = 1'b1;
                  RegWrite  = 1'b1;
                  ResultSrc = RES_PC4;
                  w_next    = S_FETCH;
               end
               default: w_next = S_TRAP;
            endcase
         end

         // Only lw/sw reach MEM; address controls stay as in EXEC so the
         // address is stable for the whole request.
         S_MEM: begin
            dmem_req = 1'b1;
            ALUSrc   = 1'b1;
            ImmSrc   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
            MemWrite = (w_opcode == OP_STORE);
            if (dmem_ready) begin
               if (w_opcode == OP_STORE) begin
                  PCWrite = 1'b1;
                  w_next  = S_FETCH;
               end else begin
                  w_next  = S_WB;
               end
            end
         end

         S_WB: begin
            RegWrite  = 1'b1;
            ResultSrc = RES_MEM;
            PCWrite   = 1'b1;
            w_next    = S_FETCH;
         end

         S_TRAP: begin
            trap = 1'b1;
         end

         default: w_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_core_mc_controller.sv
// tb_core_mc_controller
//   Directed bench for core_mc_controller: linear sequence of instructions
//   with hand-computed expected controls.
module tb_core_mc_controller;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic        Zero;
   logic        dmem_req;
   logic        dmem_ready;
   logic        MemWrite;
   logic        PCWrite;
   logic        RegWrite;
   logic        PCSrc;
   logic        ALUSrc;
   logic        SSSrc;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [3:0]  ALUControl;
   logic        trap;
   logic [31:0] retired;

   int n_checks = 0;
   int n_errors = 0;

   core_mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .Instr      (Instr),
      .Zero       (Zero),
      .dmem_req   (dmem_req),
      .dmem_ready (dmem_ready),
      .MemWrite   (MemWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .PCSrc      (PCSrc),
      .ALUSrc     (ALUSrc),
      .SSSrc      (SSSrc),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .trap       (trap),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called while in FETCH: present a zero-wait fetch, ending in EXEC.
   task automatic fetch(input logic [31:0] ins);
      imem_rdata = ins;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
   endtask

   logic [4:0] strobes_seen;
   int         dreq_cycles;

   initial begin
      reset      = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      Zero       = 1'b0;
      dmem_ready = 1'b0;
      tick();
      tick();
      chk("rst_instr",   Instr, 32'h0);
      chk("rst_retired", retired, 32'h0);
      chk("rst_trap",    {31'b0, trap}, 32'h0);
      chk("rst_imemreq", {31'b0, imem_req}, 32'h1);
      reset = 1'b0;
      tick();
      chk("fetch_wait_req", {31'b0, imem_req}, 32'h1);

      // add x3,x1,x2
      fetch(32'h002081B3);
      chk("add_instr",   Instr, 32'h002081B3);
      chk("add_strobes", {28'b0, RegWrite, PCWrite, imem_req, SSSrc}, {28'b0, 4'b1100});
      chk("add_alu",     {28'b0, ALUControl}, 32'h0);
      chk("add_res",     {30'b0, ResultSrc}, 32'h0);
      tick();
      chk("add_retired", retired, 32'd1);
      chk("add_refetch", {31'b0, imem_req}, 32'h1);

      // lw with dmem_ready delayed 3 cycles: FETCH, EXEC, 4x MEM, WB = 7
      fetch(32'h0000A103);
      chk("lw_exec", {24'b0, RegWrite, PCWrite, dmem_req, ALUSrc, ImmSrc, ALUControl[1:0]},
          {24'b0, 8'b0001_0000});
      chk("lw_exec_alu", {28'b0, ALUControl}, 32'h0);
      dreq_cycles = 0;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (dmem_req === 1'b1) dreq_cycles++;
         chk("lw_mem_wait", {29'b0, PCWrite, RegWrite, MemWrite}, 32'h0);
         tick();
      end
      if (dmem_req === 1'b1) dreq_cycles++;
      dmem_ready = 1'b1;
      #1;
      chk("lw_mem_last", {28'b0, PCWrite, RegWrite, MemWrite, ALUSrc}, 32'h1);
      tick();
      dmem_ready = 1'b0;
      chk("lw_dreq_cycles", dreq_cycles, 32'd4);
      chk("lw_wb", {26'b0, dmem_req, RegWrite, PCWrite, 1'b0, ResultSrc}, {26'b0, 6'b011001});
      tick();
      chk("lw_retired", retired, 32'd2);
      chk("lw_back_fetch", {31'b0, imem_req}, 32'h1);

      // beq x1,x2,8
      fetch(32'h00208463);
      Zero = 1'b1;
      #1;
      chk("beq_z1", {28'b0, PCSrc, PCWrite, RegWrite, 1'b0}, {28'b0, 4'b1100});
      chk("beq_imm_alu", {26'b0, ImmSrc, ALUControl}, {26'b0, 2'b10, 4'b0001});
      Zero = 1'b0;
      #1;
      chk("beq_z0", {28'b0, PCSrc, PCWrite, RegWrite, 1'b0}, {28'b0, 4'b0100});
      tick();
      chk("beq_retired", retired, 32'd3);

      // custom-0
      fetch(32'h0020818B);
      chk("cust_ss", {28'b0, SSSrc, RegWrite, PCWrite, 1'b0}, {28'b0, 4'b1110});
      chk("cust_alu", {28'b0, ALUControl}, 32'h0);
      tick();

      // sub x3,x1,x2
      fetch(32'h402081B3);
      chk("sub_alu", {28'b0, ALUControl}, 32'h1);
      chk("sub_ss",  {31'b0, SSSrc}, 32'h0);
      tick();

      // sra x3,x1,x2
      fetch(32'h4020D1B3);
      chk("sra_alu", {28'b0, ALUControl}, 32'h8);
      tick();
      chk("r_retired6", retired, 32'd6);

      // sw x2,4(x1), zero-wait: 3 cycles
      fetch(32'h0020A223);
      chk("sw_exec", {27'b0, ALUSrc, ImmSrc, dmem_req, PCWrite}, {27'b0, 5'b10100});
      tick();
      dmem_ready = 1'b1;
      #1;
      chk("sw_mem", {27'b0, dmem_req, MemWrite, PCWrite, RegWrite, ALUSrc}, {27'b0, 5'b11101});
      tick();
      dmem_ready = 1'b0;
      chk("sw_retired", retired, 32'd7);
      chk("sw_fetch", {30'b0, imem_req, dmem_req}, 32'h2);

      // sw interrupted by reset mid-MEM
      fetch(32'h0020A223);
      tick();
      chk("swr_mem", {30'b0, dmem_req, MemWrite}, 32'h3);
      reset = 1'b1;
      tick();
      chk("swr_drop", {29'b0, dmem_req, MemWrite, imem_req}, 32'h1);
      chk("swr_retired", retired, 32'd0);
      reset = 1'b0;
      tick();
      chk("swr_refetch", {31'b0, imem_req}, 32'h1);
      fetch(32'h002081B3);
      chk("swr_resume", Instr, 32'h002081B3);
      tick();
      chk("swr_retired1", retired, 32'd1);

      // illegal opcode
      fetch(32'h0000007F);
      chk("ill_exec", {27'b0, imem_req, dmem_req, PCWrite, RegWrite, MemWrite}, 32'h0);
      tick();
      chk("ill_trap", {31'b0, trap}, 32'h1);
      strobes_seen = '0;
      imem_ready   = 1'b1;
      dmem_ready   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         strobes_seen = strobes_seen | {imem_req, dmem_req, PCWrite, RegWrite, MemWrite};
         tick();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      chk("ill_quiet",   {27'b0, strobes_seen}, 32'h0);
      chk("ill_sticky",  {31'b0, trap}, 32'h1);
      chk("ill_retired", retired, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("ill_clear", {30'b0, trap, imem_req}, 32'h1);
      chk("ill_instr0", Instr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/core_mc_controller.md
# core_mc_controller

Multi-cycle control sequencer for the superscalar RISC-V core datapath. It fetches each instruction over a ready/valid instruction-memory handshake and holds it in an instruction register. It decodes the instruction and steps the datapath through execute, memory and writeback states, driving every datapath control input and the PC/register write strobes. It sits between instruction/data memory and the core datapath and replaces a purely combinational decoder.

## Interface
- No parameters; encodings live in the shared package.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request, held until imem_ready
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- Instr  out  32  instruction register, driven to the datapath
- Zero  in  1  ALU zero flag from the datapath
- dmem_req  out  1  data access request, held until dmem_ready
- dmem_ready  in  1  data access complete (ReadData valid for loads)
- MemWrite  out  1  store qualifier, valid while dmem_req is high
- PCWrite  out  1  datapath PC update enable
- RegWrite  out  1  register-file write strobe
- PCSrc  out  1  0 = PC+4, 1 = PC target
- ALUSrc  out  1  0 = register, 1 = immediate
- SSSrc  out  1  1 = ALU_Array result, 0 = scalar ALU result
- ResultSrc  out  2  00 = ALU, 01 = ReadData, 10 = PC+4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  4  ALU operation
- trap  out  1  illegal opcode seen; sticky until reset
- retired  out  32  retired-instruction count

## Operation
- States: FETCH, EXEC, MEM, WB, TRAP. Reset state is FETCH. After reset, Instr = 0 and retired = 0.
- FETCH: imem_req = 1. On imem_ready, Instr <= imem_rdata and the FSM moves to EXEC. No other strobes are active.
- EXEC: decode opcode Instr[6:0].
  - R-type 0110011, I-ALU 0010011, custom-0 0001011:
    - RegWrite = 1, PCWrite = 1, ResultSrc = 00.
    - SSSrc = 1 only for custom-0.
    - Next state FETCH.
  - lw 0000011: ALUSrc = 1, ImmSrc = 00, ADD. Next state MEM.
  - sw 0100011: ALUSrc = 1, ImmSrc = 01, ADD. Next state MEM.
  - beq 1100011:
    - ImmSrc = 10, SUB, PCWrite = 1, PCSrc = Zero.
    - Next state FETCH.
  - jal 1101111:
    - ImmSrc = 11, PCSrc = 1, PCWrite = 1, RegWrite = 1, ResultSrc = 10.
    - Next state FETCH.
  - Any other opcode: next state TRAP. No strobes are issued.
- MEM: dmem_req = 1, with ALUSrc/ImmSrc/ALUControl held from EXEC.
  - Store: MemWrite = 1. On dmem_ready, PCWrite = 1 and the FSM moves to FETCH.
  - Load: on dmem_ready, the FSM moves to WB.
- WB (load only): RegWrite = 1, ResultSrc = 01, PCWrite = 1. Next state FETCH.
- TRAP: trap = 1 and all strobes are 0. Only reset leaves this state.
- ALUControl decode uses funct3 and funct7[5]:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000.
  - SUB applies only for R-type with funct7[5] = 1.
  - SRA applies when funct3 = 101 and funct7[5] = 1.
- retired increments by 1 in every cycle where PCWrite = 1. It wraps from 0xFFFFFFFF to 0.

## Timing
- All controls are combinational from the registered state and Instr. There are no outputs from imem_rdata directly.
- Minimum cycles per instruction with zero-wait memories (ready in the first request cycle):
  - R/I/custom/beq/jal: 2
  - sw: 3
  - lw: 4
- Requests are held high with stable controls until ready. ready while req is low is ignored.
- Reset has priority over every transition. Reset during a wait (mid-FETCH or mid-MEM) drops the request in the next cycle, then FETCH re-requests.
- PCWrite and RegWrite are never high for more than one cycle per instruction.

## Structure
- Package core_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - the ALUControl, ResultSrc and ImmSrc encodings (shared with the ALU and the muxes).
- Sub-module core_alu_decoder: combinational funct3/funct7/opcode to ALUControl. The FSM and counter stay in the top module.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with imem_ready in the first cycle:
  - Instr = 0x002081B3 after 1 cycle;
  - next cycle RegWrite = PCWrite = 1, ALUControl = 0000;
  - retired = 1.
- lw 0x0000A103 with dmem_ready delayed 3 cycles:
  - dmem_req is held for 4 cycles;
  - WB asserts RegWrite with ResultSrc = 01;
  - 7 cycles total.
- beq 0x00208463:
  - Zero = 1 gives PCSrc = 1;
  - Zero = 0 gives PCSrc = 0;
  - both cases have PCWrite = 1 and RegWrite = 0.
- custom-0 0x0020818B gives SSSrc = 1 and RegWrite = 1. sub (funct7 = 0100000) gives ALUControl = 0001.
- Opcode 0x0000007F gives trap = 1, no further imem_req, and no strobes for 20 cycles. reset clears trap.
- Reset asserted mid-MEM of sw gives dmem_req = 0 and MemWrite = 0 on the next cycle and retired = 0. FETCH then resumes.
